// File: rtl/alu_srcb_sel_reg_if.sv
// Operand-B selector bus: channel data, select/capture controls, and the registered result.
interface alu_srcb_sel_reg_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    load;
    logic                    const_we;
    logic [WIDTH-1:0]        const_wdata;
    logic                    clr_err;
    logic                    shl2;
    logic [WIDTH-1:0]        out;
    logic                    out_valid;
    logic                    sel_err;

    modport master (
        output in_bus, sel, load, const_we, const_wdata, clr_err, shl2,
        input  out, out_valid, sel_err
    );

    modport slave (
        input  in_bus, sel, load, const_we, const_wdata, clr_err, shl2,
        output out, out_valid, sel_err
    );
endinterface

// File: rtl/alu_srcb_sel_reg.sv
// Registered ALU operand-B selector with a programmable constant channel and sticky select error.
// Optional SRCB_SHIFT_EN: shl2 on a load scales the captured operand by 4.
module alu_srcb_sel_reg #(
    parameter int WIDTH     = 32,
    parameter int NUM_IN    = 4,
    parameter int SEL_W     = 2,
    parameter int CONST_SEL = 1,
    parameter int CONST_VAL = 4
) (
    input logic              clk,
    input logic              reset,
    alu_srcb_sel_reg_if.slave bus
);
    logic [WIDTH-1:0] chan [NUM_IN];
    logic [WIDTH-1:0] pick;
    logic [WIDTH-1:0] pick_shaped;
    logic             in_range;

    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] const_q, const_d;

    // The constant channel replaces its in_bus slice entirely.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
            if (gi == CONST_SEL) begin : g_const
                assign chan[gi] = const_q;
            end else begin : g_bus
                assign chan[gi] = bus.in_bus[gi*WIDTH +: WIDTH];
            end
        end
    endgenerate

    always_comb begin
        in_range = (32'(bus.sel) < 32'(NUM_IN));
        pick     = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (32'(bus.sel) == 32'(k)) begin
                pick = chan[k];
            end
        end
    end

`ifdef SRCB_SHIFT_EN
    logic unused_bits;
    assign unused_bits = ^bus.in_bus[CONST_SEL*WIDTH +: WIDTH];
    assign pick_shaped = bus.shl2 ? (pick << 2) : pick;
`else
    logic unused_bits;
    assign unused_bits = ^{bus.in_bus[CONST_SEL*WIDTH +: WIDTH], bus.shl2};
    assign pick_shaped = pick;
`endif

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        err_d   = err_q;
        const_d = const_q;
        if (bus.const_we) begin
            const_d = bus.const_wdata;
        end
        if (bus.clr_err) begin
            err_d = 1'b0;
        end
        // A load reads the pre-write constant; a new error overrides a clear.
        if (bus.load) begin
            valid_d = 1'b1;
            if (in_range) begin
                out_d = pick_shaped;
            end else begin
                out_d = '0;
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            const_q <= WIDTH'(CONST_VAL);
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            const_q <= const_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_alu_srcb_sel_reg.sv
// Directed bench: vector table on a 4-channel instance, hand sequences on a 3-channel instance.
module tb_alu_srcb_sel_reg;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef SRCB_SHIFT_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_srcb_sel_reg_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) ifa ();
    alu_srcb_sel_reg_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) ifb ();

    alu_srcb_sel_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .CONST_SEL(1), .CONST_VAL(4))
        dut_a (.clk(clk), .reset(rst_a), .bus(ifa.slave));
    alu_srcb_sel_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .CONST_SEL(1), .CONST_VAL(4))
        dut_b (.clk(clk), .reset(rst_b), .bus(ifb.slave));

    typedef struct {
        logic         rst_n;
        logic         load;
        logic [1:0]   sel;
        logic [127:0] in_bus;
        logic         cwe;
        logic [31:0]  cwd;
        logic         clr;
        logic         shl2;
        logic [31:0]  e_out;
        logic         e_valid;
        logic         e_err;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic rst_n, logic load, logic [1:0] sel, logic [127:0] in_bus,
                                logic cwe, logic [31:0] cwd, logic shl2,
                                logic [31:0] e_out, logic e_valid);
        vec_t v;
        v.rst_n = rst_n; v.load = load; v.sel = sel; v.in_bus = in_bus;
        v.cwe = cwe; v.cwd = cwd; v.clr = 1'b0; v.shl2 = shl2;
        v.e_out = e_out; v.e_valid = e_valid; v.e_err = 1'b0;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic step_b(logic rst_n, logic load, logic [1:0] sel, logic [95:0] in_bus,
                          logic clr, logic shl2, logic [31:0] e_out, logic e_valid,
                          logic e_err, string name);
        @(negedge clk);
        rst_b = rst_n; ifb.load = load; ifb.sel = sel; ifb.in_bus = in_bus;
        ifb.clr_err = clr; ifb.shl2 = shl2;
        @(posedge clk);
        #1;
        chk({name, ".out"},   ifb.out, e_out);
        chk({name, ".valid"}, 32'(ifb.out_valid), 32'(e_valid));
        chk({name, ".err"},   32'(ifb.sel_err), 32'(e_err));
        $display("b %-10s out=%08h valid=%0b err=%0b", name, ifb.out, ifb.out_valid, ifb.sel_err);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        ifa.in_bus = '0; ifa.sel = '0; ifa.load = 0; ifa.const_we = 0;
        ifa.const_wdata = '0; ifa.clr_err = 0; ifa.shl2 = 0;
        ifb.in_bus = '0; ifb.sel = '0; ifb.load = 0; ifb.const_we = 0;
        ifb.const_wdata = '0; ifb.clr_err = 0; ifb.shl2 = 0;

        vecs[0]  = mk(0, 0, 2'd0, '0, 0, 32'h0, 0, 32'h0, 0);
        vecs[1]  = mk(1, 1, 2'd1, {32'h0, 32'h0, 32'hFFFFFFFF, 32'h0}, 0, 32'h0, 0, 32'h4, 1);
        vecs[2]  = mk(1, 1, 2'd0, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 0, 32'h0, 0, 32'hDEADBEEF, 1);
        vecs[3]  = mk(1, 0, 2'd0, '0, 0, 32'h0, 0, 32'hDEADBEEF, 1);
        vecs[4]  = mk(1, 0, 2'd3, {32'h1234, 96'h0}, 0, 32'h0, 0, 32'hDEADBEEF, 1);
        vecs[5]  = mk(1, 1, 2'd1, '0, 1, 32'h8, 0, 32'h4, 1);
        vecs[6]  = mk(1, 1, 2'd1, '0, 0, 32'h0, 0, 32'h8, 1);
        vecs[7]  = mk(1, 1, 2'd3, {32'h12345678, 96'h0}, 0, 32'h0, 0, 32'h12345678, 1);
        vecs[8]  = mk(1, 1, 2'd2, {32'h0, 32'h40000001, 64'h0}, 0, 32'h0, 1,
                      SH ? 32'h00000004 : 32'h40000001, 1);
        vecs[9]  = mk(1, 0, 2'd2, {32'h0, 32'hFFFFFFFF, 64'h0}, 0, 32'h0, 1,
                      SH ? 32'h00000004 : 32'h40000001, 1);
        vecs[10] = mk(1, 1, 2'd0, {96'h0, 32'hDEADBEEF}, 0, 32'h0, 0, 32'hDEADBEEF, 1);
        vecs[11] = mk(0, 1, 2'd0, {96'h0, 32'h11111111}, 0, 32'h0, 0, 32'h0, 0);
        vecs[12] = mk(1, 1, 2'd1, '0, 0, 32'h0, 0, 32'h4, 1);
        vecs[13] = mk(1, 0, 2'd1, '0, 1, 32'hA5A5A5A5, 0, 32'h4, 1);
        vecs[14] = mk(1, 1, 2'd1, '0, 0, 32'h0, 0, 32'hA5A5A5A5, 1);
        vecs[15] = mk(1, 1, 2'd1, '0, 0, 32'h0, 1, SH ? 32'h96969694 : 32'hA5A5A5A5, 1);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst_a = vecs[i].rst_n; ifa.load = vecs[i].load; ifa.sel = vecs[i].sel;
            ifa.in_bus = vecs[i].in_bus; ifa.const_we = vecs[i].cwe;
            ifa.const_wdata = vecs[i].cwd; ifa.clr_err = vecs[i].clr; ifa.shl2 = vecs[i].shl2;
            @(posedge clk);
            #1;
            chk($sformatf("a%0d.out", i),   ifa.out, vecs[i].e_out);
            chk($sformatf("a%0d.valid", i), 32'(ifa.out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("a%0d.err", i),   32'(ifa.sel_err), 32'(vecs[i].e_err));
            $display("a vec%0d out=%08h valid=%0b err=%0b", i, ifa.out, ifa.out_valid, ifa.sel_err);
        end

        // Three-channel instance: sel 3 is out of range.
        step_b(0, 1, 2'd2, {32'h55, 64'h0}, 0, 0, 32'h0,  0, 0, "reset");
        step_b(1, 1, 2'd2, {32'h55, 64'h0}, 0, 0, 32'h55, 1, 0, "load2");
        step_b(1, 0, 2'd3, '0,              0, 0, 32'h55, 1, 0, "oor_noload");
        step_b(1, 1, 2'd3, {32'h77, 64'h0}, 0, 0, 32'h0,  1, 1, "oor_load");
        step_b(1, 1, 2'd3, '0,              1, 0, 32'h0,  1, 1, "clr_vs_set");
        step_b(1, 0, 2'd0, '0,              1, 0, 32'h0,  1, 0, "clr");
        step_b(1, 1, 2'd0, {64'h0, 32'h9},  0, 0, 32'h9,  1, 0, "load0");
        step_b(1, 1, 2'd3, '0,              0, 1, 32'h0,  1, 1, "oor_shl2");
        step_b(1, 0, 2'd0, '0,              0, 0, 32'h0,  1, 1, "sticky");
        step_b(0, 0, 2'd0, '0,              0, 0, 32'h0,  0, 0, "reset2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_srcb_sel_reg.md
Name: alu_srcb_sel_reg

Overview:
- Parametrised, registered successor of the ALU operand-B selector for the multicycle datapath.
- Selects one of NUM_IN operand channels. One channel is a programmable constant register (reset value CONST_VAL, i.e. the PC increment 4).
- Captures the selection into an output register under a load strobe and holds it otherwise.
- Flags out-of-range selects with a sticky error.

Parameters:
- WIDTH, 32, data width of every channel and of the output
- NUM_IN, 4, number of channels, legal range 2..8
- SEL_W, 2, select width; requires 2**SEL_W >= NUM_IN
- CONST_SEL, 1, channel index served by the internal constant register; its in_bus slice is ignored
- CONST_VAL, 4, reset value of the constant register

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-low; sampled on clk rising edge
- in_bus  in  NUM_IN*WIDTH  flattened channels; channel k = in_bus[k*WIDTH +: WIDTH]
- sel  in  SEL_W  channel select
- load  in  1  capture strobe
- const_we  in  1  constant register write enable
- const_wdata  in  WIDTH  new constant value
- clr_err  in  1  clears sel_err
- shl2  in  1  shift-left-2 request (see Optional Feature)
- out  out  WIDTH  registered operand B
- out_valid  out  1  out holds a captured value
- sel_err  out  1  sticky out-of-range select flag

Behaviour:
- Reset (reset==0 at clk edge):
  - out=0, out_valid=0, sel_err=0, const_reg=CONST_VAL.
  - Reset has priority over all other inputs in that cycle.
- Combinational pick:
  - sel==CONST_SEL selects const_reg.
  - Any other sel < NUM_IN selects channel sel.
  - sel >= NUM_IN selects 0.
- Capture:
  - load==1 at clk edge: out <= pick, one-cycle latency; out_valid <= 1.
  - load==0: out and out_valid hold.
  - out_valid stays 1 until reset; it is never cleared by a hold.
- Error:
  - load==1 with sel >= NUM_IN: sel_err <= 1 and out <= 0.
  - sel_err stays set until clr_err==1 or reset.
  - Out-of-range sel without load does not set sel_err.
  - Simultaneous clr_err and a new error: set wins, sel_err=1.
- Constant register:
  - const_we==1: const_reg <= const_wdata at clk edge.
  - Simultaneous const_we and load with sel==CONST_SEL: out captures the OLD const_reg. The new value is visible from the next load.
- Channel changes without load have no effect on out. No combinational path from inputs to out.
- Reset mid-sequence: a pending load in the reset cycle is discarded; all state returns to reset values.
- Width rules:
  - All data is unsigned and exactly WIDTH bits.
  - Shift (when enabled) discards the top 2 bits and zero-fills the bottom 2.

Optional Feature:
- Macro: SRCB_SHIFT_EN
- Defined: on load with shl2==1, out <= pick << 2, truncated to WIDTH. This is used for branch-offset scaling. shl2 has no effect without load. With an out-of-range sel, out is still 0.
- Not defined: shl2 is ignored, and out <= pick on every load. The shl2 port remains on the interface so instantiations are unchanged.

Test Plan:
- Reset then load=1, sel=CONST_SEL(1) -> next cycle out=32'h00000004, out_valid=1, sel_err=0.
- Channel 0=32'hDEADBEEF, load=1, sel=0; next cycle load=0 and channel 0=32'h0 -> out=32'hDEADBEEF captured and held while load is low.
- const_we=1, const_wdata=32'h8 together with load=1, sel=1 -> out=4 that cycle. Following load with sel=1 -> out=8.
- NUM_IN=3, SEL_W=2: load=1, sel=3 -> out=0, sel_err=1. Next cycle clr_err=1 with load=1, sel=3 -> sel_err stays 1. Then clr_err=1 alone -> sel_err=0.
- SRCB_SHIFT_EN defined: channel 2=32'h40000001, load=1, sel=2, shl2=1 -> out=32'h00000004. Undefined build, same stimulus -> out=32'h40000001.
- After out=32'hDEADBEEF, reset=0 for one cycle while load=1, sel=0 -> out=0, out_valid=0, const_reg=4. The load is not applied.
